// File: rtl/hamming_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hamming_pkg : shared widths, op/state enums and codeword layout helper
// Rev 1.0
// ---------------------------------------------------------------------------
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 15;
    localparam int SYN_W  = 4;

    typedef enum logic {
        OP_ENC = 1'b0,
        OP_DEC = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Codeword position (1..15) holding data bit i; bit 10 sits lowest at position 3.
    function automatic int data_pos(input int i);
        int j;
        j = (DATA_W - 1) - i;
        if (j == 0)
            return 3;
        else if (j <= 3)
            return j + 4;
        else
            return j + 5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hamming_arb_if : per-requester command/response bundle for hamming_arb
// Rev 1.0
// ---------------------------------------------------------------------------
interface hamming_arb_if
    import hamming_pkg::*;
#(
    parameter int N_REQ = 2
);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_op;
    logic [N_REQ-1:0][CODE_W-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0]             resp_valid;
    logic [N_REQ-1:0]             resp_ready;
    logic [CODE_W-1:0]            resp_data;
    logic [SYN_W-1:0]             resp_syn;
    logic                         resp_err;

    modport master (
        output req_valid, req_op, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_syn, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_syn, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/hamming_codec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hamming_codec : combinational Hamming(15,11) encoder / single-error corrector
// Rev 1.0
// ---------------------------------------------------------------------------
module hamming_codec
    import hamming_pkg::*;
(
    input  op_e               op,
    input  logic [CODE_W-1:0] din,
    output logic [CODE_W-1:0] dout,
    output logic [SYN_W-1:0]  syn
);

    logic [CODE_W-1:0] w_cw;
    logic [SYN_W-1:0]  w_syn;
    logic [CODE_W-1:0] w_fix;
    logic [DATA_W-1:0] w_dat;
    logic              w_par;

    // Position p lives at bit CODE_W-p, so position 1 is the MSB.
    always_comb begin
        w_cw = '0;
        for (int i = 0; i < DATA_W; i++)
            w_cw[CODE_W - data_pos(i)] = din[i];
        for (int b = 0; b < SYN_W; b++) begin
            w_par = 1'b0;
            for (int p = 1; p <= CODE_W; p++)
                if (((p >> b) & 1) == 1)
                    w_par = w_par ^ w_cw[CODE_W - p];
            w_cw[CODE_W - (1 << b)] = w_par;
        end
    end

    always_comb begin
        w_syn = '0;
        for (int p = 1; p <= CODE_W; p++)
            if (din[CODE_W - p])
                w_syn = w_syn ^ SYN_W'(p);
        w_fix = din;
        for (int p = 1; p <= CODE_W; p++)
            if (w_syn == SYN_W'(p))
                w_fix[CODE_W - p] = ~din[CODE_W - p];
        w_dat = '0;
        for (int i = 0; i < DATA_W; i++)
            w_dat[i] = w_fix[CODE_W - data_pos(i)];
    end

    always_comb begin
        if (op == OP_ENC) begin
            dout = w_cw;
            syn  = '0;
        end else begin
            dout = {{(CODE_W-DATA_W){1'b0}}, w_dat};
            syn  = w_syn;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hamming_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hamming_arb : round-robin arbiter sharing one Hamming codec among N_REQ users
// Rev 1.0
// ---------------------------------------------------------------------------
module hamming_arb
    import hamming_pkg::*;
#(
    parameter int N_REQ = 2
)(
    input  logic          clk,
    input  logic          rst,
    hamming_arb_if.slave  arb_if
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_q;
    op_e                op_q;
    logic [CODE_W-1:0]  operand_q;
    logic [CODE_W-1:0]  resp_data_q;
    logic [SYN_W-1:0]   resp_syn_q;
    logic               resp_err_q;

    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_win;
    logic               w_any;
    logic [CODE_W-1:0]  w_cdout;
    logic [SYN_W-1:0]   w_csyn;
    logic [N_REQ-1:0]   w_req_ready;
    logic [N_REQ-1:0]   w_resp_valid;

    // Rotate valids so bit 0 is the requester at the pointer; first set bit wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        w_rot = N_REQ'({arb_if.req_valid, arb_if.req_valid} >> ptr_q);
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any && w_rot[i]) begin
                w_any = 1'b1;
                w_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
                if (w_sum >= (IDX_W+1)'(N_REQ))
                    w_sum = w_sum - (IDX_W+1)'(N_REQ);
                w_win = w_sum[IDX_W-1:0];
            end
        end
    end

    assign ptr_d = (w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (arb_if.resp_ready[grant_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_req_ready  = '0;
        w_resp_valid = '0;
        if (!rst && state_q == IDLE && w_any)
            w_req_ready[w_win] = 1'b1;
        if (state_q == RESP)
            w_resp_valid[grant_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            grant_q     <= '0;
            op_q        <= OP_ENC;
            operand_q   <= '0;
            resp_data_q <= '0;
            resp_syn_q  <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && w_any) begin
                ptr_q     <= ptr_d;
                grant_q   <= w_win;
                op_q      <= op_e'(arb_if.req_op[w_win]);
                operand_q <= arb_if.req_data[w_win];
            end
            if (state_q == EXEC) begin
                resp_data_q <= w_cdout;
                resp_syn_q  <= w_csyn;
                resp_err_q  <= (w_csyn != '0);
            end
        end
    end

    hamming_codec u_codec (
        .op   (op_q),
        .din  (operand_q),
        .dout (w_cdout),
        .syn  (w_csyn)
    );

    assign arb_if.req_ready  = w_req_ready;
    assign arb_if.resp_valid = w_resp_valid;
    assign arb_if.resp_data  = resp_data_q;
    assign arb_if.resp_syn   = resp_syn_q;
    assign arb_if.resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hamming_arb : vector table, directed corner sequences and random traffic
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hamming_arb;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   mptr  = 0;

    always #5 clk = ~clk;

    hamming_arb_if #(.N_REQ(N)) bus ();

    hamming_arb #(.N_REQ(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (bus)
    );

    typedef struct {
        logic        op;
        logic [14:0] din;
        logic [14:0] dout;
        logic [3:0]  syn;
        logic        err;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Syndrome = XOR of indices of set positions (position p at bit 15-p).
    function automatic logic [3:0] m_syn(input logic [14:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int p = 1; p <= 15; p++)
            if (cw[15-p]) s = s ^ 4'(p);
        return s;
    endfunction

    // Encode: scatter data, then set parity bits so the codeword syndrome is zero.
    function automatic logic [14:0] m_enc(input logic [10:0] d);
        logic [14:0] cw;
        logic [3:0]  s;
        int          k;
        cw = 15'd0;
        k  = 10;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin
                cw[15-p] = d[k];
                k--;
            end
        s = m_syn(cw);
        for (int b = 0; b < 4; b++)
            if (s[b]) cw[15-(1<<b)] = 1'b1;
        return cw;
    endfunction

    function automatic logic [14:0] m_dec(input logic [14:0] cw);
        logic [14:0] c;
        logic [3:0]  s;
        logic [10:0] d;
        int          k;
        s = m_syn(cw);
        c = cw;
        if (s != 4'd0) c[15-s] = ~c[15-s];
        d = 11'd0;
        k = 10;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin
                d[k] = c[15-p];
                k--;
            end
        return {4'd0, d};
    endfunction

    task automatic cmd(input int r, input vec_t v, input string nm);
        @(negedge clk);
        bus.req_valid     = '0;
        bus.req_valid[r]  = 1'b1;
        bus.req_op[r]     = v.op;
        bus.req_data[r]   = v.din;
        bus.resp_ready    = '1;
        #1 chk({nm, ".ready"}, 32'(bus.req_ready), 32'(1 << r));
        mptr = (r + 1) % N;
        @(negedge clk);
        bus.req_valid = '0;
        #1 chk({nm, ".exec_rv"}, 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({nm, ".rv"},   32'(bus.resp_valid), 32'(1 << r));
        chk({nm, ".data"}, 32'(bus.resp_data),  32'(v.dout));
        chk({nm, ".syn"},  32'(bus.resp_syn),   32'(v.syn));
        chk({nm, ".err"},  32'(bus.resp_err),   32'(v.err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] rr_data [N];
        int          gcyc [$];
        int          gidx [$];
        int          last_g;

        tbl[0]  = '{1'b0, 15'h0000, 15'h0000, 4'd0,  1'b0};
        tbl[1]  = '{1'b0, 15'h07FF, 15'h7FFF, 4'd0,  1'b0};
        tbl[2]  = '{1'b1, 15'h7FFF, 15'h07FF, 4'd0,  1'b0};
        tbl[3]  = '{1'b1, 15'h7BFF, 15'h07FF, 4'd5,  1'b1};
        tbl[4]  = '{1'b0, 15'h0400, 15'h7000, 4'd0,  1'b0};
        tbl[5]  = '{1'b0, 15'h0001, 15'h6881, 4'd0,  1'b0};
        tbl[6]  = '{1'b1, 15'h6881, 15'h0001, 4'd0,  1'b0};
        tbl[7]  = '{1'b1, 15'h6880, 15'h0001, 4'd15, 1'b1};
        tbl[8]  = '{1'b1, 15'h4000, 15'h0000, 4'd1,  1'b1};
        tbl[9]  = '{1'b1, 15'h1FFF, 15'h03FF, 4'd3,  1'b1};
        tbl[10] = '{1'b0, 15'h7800, 15'h0000, 4'd0,  1'b0};

        // Reset state with every requester asking.
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.req_op     = '0;
        bus.req_data   = '0;
        bus.resp_ready = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.ready", 32'(bus.req_ready),  32'd0);
        chk("rst.rv",    32'(bus.resp_valid), 32'd0);
        chk("rst.data",  32'(bus.resp_data),  32'd0);
        chk("rst.syn",   32'(bus.resp_syn),   32'd0);
        chk("rst.err",   32'(bus.resp_err),   32'd0);

        // Both requesters hold valid from reset release: grants 0,1,0,1 every 3 cycles.
        @(negedge clk);
        rr_data[0]      = 15'h0001;
        rr_data[1]      = 15'h0400;
        bus.req_data[0] = rr_data[0];
        bus.req_data[1] = rr_data[1];
        bus.resp_ready  = '1;
        rst             = 1'b0;
        last_g          = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                last_g = (bus.req_ready == 2'b01) ? 0 : 1;
                gcyc.push_back(c);
                gidx.push_back(last_g);
            end
            if (bus.resp_valid != '0) begin
                chk("rr.rv",   32'(bus.resp_valid), 32'(1 << last_g));
                chk("rr.data", 32'(bus.resp_data),  32'(m_enc(rr_data[last_g][10:0])));
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        chk("rr.count", 32'(gcyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gcyc.size()) begin
                chk("rr.idx", 32'(gidx[i]), 32'(i % 2));
                chk("rr.cyc", 32'(gcyc[i]), 32'(3 * i));
            end
        end
        mptr = 0;

        for (int i = 0; i < 11; i++)
            cmd(i % N, tbl[i], $sformatf("vec%0d", i));

        // Stalled response while req 1 waits and drives its own resp_ready.
        @(negedge clk);
        bus.req_valid   = 2'b01;
        bus.req_op[0]   = 1'b1;
        bus.req_data[0] = 15'h7BFF;
        bus.resp_ready  = 2'b00;
        #1 chk("stall.accept", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b10;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.req_valid   = 2'b10;
            bus.req_op[1]   = 1'b0;
            bus.req_data[1] = 15'h0000;
            bus.resp_ready  = 2'b10;
            #1;
            chk("stall.rv",    32'(bus.resp_valid), 32'd1);
            chk("stall.data",  32'(bus.resp_data),  32'h07FF);
            chk("stall.syn",   32'(bus.resp_syn),   32'd5);
            chk("stall.err",   32'(bus.resp_err),   32'd1);
            chk("stall.ready", 32'(bus.req_ready),  32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 2'b01;
        #1 chk("stall.ready_hs", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("stall.rv_after", 32'(bus.resp_valid), 32'd0);
        chk("stall.next",     32'(bus.req_ready),  32'd2);
        @(negedge clk);
        bus.req_valid  = '0;
        bus.resp_ready = '1;
        @(negedge clk);
        #1;
        chk("stall.req1_rv",   32'(bus.resp_valid), 32'd2);
        chk("stall.req1_data", 32'(bus.resp_data),  32'h0000);

        // Reset during EXEC: command dropped, pointer back to 0.
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1 chk("rexec.accept", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst           = 1'b1;
        #1 chk("rexec.rv_rst", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rexec.rv", 32'(bus.resp_valid), 32'd0);
            @(negedge clk);
        end
        bus.req_valid = 2'b11;
        #1 chk("rexec.ptr0", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1 chk("rexec.rv_new", 32'(bus.resp_valid), 32'd1);
        mptr = 1;

        // Randomized traffic against the transaction-level model.
        for (int t = 0; t < 150; t++) begin
            logic [N-1:0] v;
            logic [14:0]  d [N];
            logic         o [N];
            logic [14:0]  ed;
            logic [3:0]   es;
            int           w;
            bit           done;

            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid  = '0;
                bus.resp_ready = N'($urandom);
                #1 chk("rnd.idle", 32'(bus.req_ready), 32'd0);
                @(negedge clk);
            end
            v = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                o[i] = 1'($urandom);
                d[i] = 15'($urandom);
                if ($urandom_range(0, 1) == 0)
                    d[i] = m_enc(11'($urandom)) ^ (15'd1 << $urandom_range(0, 14));
                bus.req_op[i]   = o[i];
                bus.req_data[i] = d[i];
            end
            bus.req_valid  = v;
            bus.resp_ready = N'($urandom);
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && v[(mptr + i) % N]) w = (mptr + i) % N;
            #1 chk("rnd.grant", 32'(bus.req_ready), 32'(1 << w));
            mptr = (w + 1) % N;
            if (o[w]) begin
                ed = m_dec(d[w]);
                es = m_syn(d[w]);
            end else begin
                ed = m_enc(d[w][10:0]);
                es = 4'd0;
            end
            @(negedge clk);
            bus.req_valid  = N'($urandom);
            bus.resp_ready = N'($urandom);
            #1 chk("rnd.exec", 32'({bus.req_ready, bus.resp_valid}), 32'd0);
            done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                @(negedge clk);
                bus.req_valid  = N'($urandom);
                bus.resp_ready = N'($urandom);
                if (k == 19) bus.resp_ready[w] = 1'b1;
                #1;
                chk("rnd.rv",    32'(bus.resp_valid), 32'(1 << w));
                chk("rnd.data",  32'(bus.resp_data),  32'(ed));
                chk("rnd.syn",   32'(bus.resp_syn),   32'(es));
                chk("rnd.err",   32'(bus.resp_err),   32'(es != 4'd0));
                chk("rnd.ready", 32'(bus.req_ready),  32'd0);
                done = bus.resp_ready[w];
            end
        end

        @(negedge clk);
        bus.req_valid = '0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_arb.md
HAMMING_ARB -- requirements
Module: hamming_arb

Interface
REQ-001 Parameter N_REQ, default 2, meaning number of requesters sharing the codec (2..4).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  N_REQ  per-requester command valid.
REQ-005 req_op  input  N_REQ  per-requester operation: 0 = encode, 1 = decode.
REQ-006 req_data  input  N_REQ x 15  per-requester operand; encode uses bits [10:0], ignores [14:11].
REQ-007 req_ready  output  N_REQ  per-requester command accept; a command transfers when valid and ready are both 1.
REQ-008 resp_valid  output  N_REQ  per-requester result valid.
REQ-009 resp_ready  input  N_REQ  per-requester result accept.
REQ-010 resp_data  output  15  result: encode gives a 15-bit codeword; decode gives corrected data in [10:0], zero in [14:11].
REQ-011 resp_syn  output  4  decode syndrome; 0 for encode.
REQ-012 resp_err  output  1  decode only: 1 when the syndrome is non-zero (single-bit error corrected).

Function
REQ-013 Codeword positions 1..15 SHALL map to resp_data[14:0], with position 1 at bit 14.
REQ-014 Parity SHALL occupy positions 1, 2, 4 and 8. Data bits [10:0] SHALL fill positions 3, 5-7 and 9-15 in ascending order, with data bit 10 at position 3.
REQ-015 Parity k SHALL be even parity over all positions whose index has bit k set.
REQ-016 Decode syndrome SHALL be the XOR of the indices of all set positions. A non-zero syndrome SHALL invert that position before data extraction.
REQ-017 FSM states SHALL be IDLE, EXEC and RESP.
REQ-018 In IDLE, req_ready SHALL be 1 only for the round-robin winner among asserted req_valid. At most one ready bit SHALL be high, and none when no request is valid.
REQ-019 On a transfer, the FSM SHALL capture op, operand and grant index, then go IDLE -> EXEC.
REQ-020 EXEC SHALL compute through the codec, register the results and go to RESP after exactly 1 cycle.
REQ-021 In RESP, resp_valid SHALL be high only for the granted index, and resp_data, resp_syn and resp_err SHALL be stable.
REQ-022 The FSM SHALL go RESP -> IDLE on the cycle the granted resp_ready is 1.
REQ-023 The next command SHALL not be accepted in the same cycle as that handshake. The minimum command-to-command spacing is 3 cycles.
REQ-024 Latency from the accept edge to resp_valid high SHALL be 2 cycles.
REQ-025 Round-robin pointer SHALL advance to grant index + 1 (mod N_REQ) on each accept. The search SHALL start at the pointer.
REQ-026 Simultaneous requests SHALL be served in pointer order, and no requester SHALL wait more than N_REQ-1 grants.
REQ-027 A requester dropping req_valid before it is granted SHALL be permitted and SHALL lose no state.
REQ-028 resp_ready asserted by a non-granted requester SHALL be ignored.
REQ-029 A stalled response (resp_ready held 0) SHALL hold RESP indefinitely with outputs unchanged.
REQ-030 Decode of a double-bit error SHALL be miscorrected silently with resp_err=1. No double-error detection is required.

Reset
REQ-031 While rst=1, the FSM SHALL be IDLE, the pointer 0, req_ready and resp_valid all 0, and resp_data, resp_syn and resp_err 0.
REQ-032 rst asserted in EXEC or RESP SHALL discard the in-flight command without producing a response.
REQ-033 The first accept after reset release SHALL be on the first rising edge with rst=0.

Structure
REQ-034 A shared package hamming_pkg SHALL hold DATA_W=11, CODE_W=15, SYN_W=4, the op enum (OP_ENC, OP_DEC) and the FSM state enum.
REQ-035 Codec logic SHALL be one combinational sub-module, hamming_codec (op, din[14:0] -> dout[14:0], syn[3:0]), instantiated once.
REQ-036 Arbitration and FSM SHALL live in hamming_arb.

Verification
REQ-037 Encode 11'h000 from req 0 -> resp_valid[0] 2 cycles after accept, resp_data 15'h0000, resp_syn 0, resp_err 0.
REQ-038 Encode 11'h7FF -> resp_data 15'h7FFF; decode 15'h7FFF -> resp_data 15'h07FF, resp_err 0.
REQ-039 Decode 15'h7FFF with position 5 flipped (15'h7BFF) -> resp_data 15'h07FF, resp_syn 4'd5, resp_err 1.
REQ-040 Both requesters hold valid for 4 commands from reset -> grant order 0, 1, 0, 1 with 3-cycle spacing when resp_ready is tied 1.
REQ-041 resp_ready held 0 for 10 cycles, with req 1 asserting resp_ready while req 0 is granted -> RESP held, outputs stable, no new accept.
REQ-042 rst pulsed during EXEC -> no resp_valid afterwards, pointer 0, next accept goes to req 0.
